shift_arbiter: RTL and testbench
================================

# shift_arbiter

- Shares one right-shift barrel shifter datapath among `REQ` requesters.
- Round-robin arbitration, per-requester valid/ready handshake, one registered response port tagged with the requester ID.
- Sits between the ALU issue logic and the shifter: the only block that drives the shifter's operand and shift-amount inputs.
- One operation in flight at a time.

## Interface
- `N`, 32: data width; power of two, ≥ 2.
- `REQ`, 4: number of requesters; power of two, ≥ 2.
- `Clk` input 1: single clock, rising edge.
- `Reset` input 1: reset is synchronous and active-high.
- `Req_Valid` input REQ: request valid, one bit per requester.
- `Req_Ready` output REQ: request accepted; at most one bit high per cycle.
- `Req_Data` input REQ*N: operand; requester k occupies bits [k*N +: N].
- `Req_Shift` input REQ*$clog2(N): shift amount; requester k occupies slice k.
- `Req_Left` input REQ: 1 = left shift, 0 = logical right shift.
- `Resp_Valid` output 1: result valid.
- `Resp_Ready` input 1: consumer accepts the result.
- `Resp_Data` output N: shifted result.
- `Resp_Id` output $clog2(REQ): index of the requester that owns `Resp_Data`.

## Operation
**States:** IDLE, BUSY, RESP.

**IDLE**
- If any `Req_Valid` is high, grant the first valid requester searching upward (with wrap) from `Last_Grant+1`.
- Assert `Req_Ready[g]` combinationally in the same cycle.
- On the clock edge:
  - capture the granted requester's Data, Shift and Left into operand registers;
  - capture g into the ID register and into `Last_Grant`;
  - move to BUSY.
- If no request is valid, stay in IDLE and assert no `Req_Ready`.

**BUSY**
- The shifter evaluates the registered operands.
- The result is registered into `Resp_Data`; move to RESP.
- `Req_Ready` is all zeros.

**RESP**
- `Resp_Valid`=1.
- When `Resp_Ready`=1, move to IDLE; otherwise hold.
- `Req_Ready` is all zeros.

**Arithmetic**
- Right: `Resp_Data[j]` = operand[j+s] for j < N−s, else 0.
- Left: bit-reverse the operand, apply the right shift, bit-reverse the result. This equals operand << s, zero-filled.
- The shift amount is $clog2(N) bits, so it never reaches N. s=0 passes the operand through.

**Boundary conditions**
- Requester k dropping `Req_Valid` before it is granted is legal; no state is kept for it.
- `Req_Ready` is never asserted outside IDLE.
- `Resp_Data` and `Resp_Id` are stable while `Resp_Valid`=1 and `Resp_Ready`=0.
- `Resp_Ready` outside RESP is ignored.

**Reset** (any state, including mid-operation)
- State → IDLE and the in-flight operation is dropped.
- `Last_Grant` → REQ−1, so requester 0 has top priority after reset.

## Timing
- Reset values: `Req_Ready`=0, `Resp_Valid`=0, `Resp_Data`=0, `Resp_Id`=0, operand registers 0.
- Latency: request handshake in cycle t → `Resp_Valid` high from cycle t+2.
- Peak throughput: one operation per 3 cycles. The next grant is possible in the cycle after the response handshake.
- Critical path: operand register → reversal mux → log2(N) shifter stages → reversal mux → `Resp_Data` register.
- No combinational path from `Resp_Ready` to any `Req_Ready`.

## Configuration
- Macro: `SHIFT_ARB_LEFT_EN`.
- Defined: left shifts are supported through the bit-reversal muxes.
- Undefined:
  - reversal muxes are not built;
  - `Req_Left` is ignored (the port remains) and every operation is a logical right shift;
  - the Left operand register is removed.

## Structure
- Package `shift_arb_pkg`:
  - state enum (IDLE, BUSY, RESP);
  - localparam functions for `SHW`=$clog2(N) and `IDW`=$clog2(REQ).
- Sub-module `shift_rr_grant`: combinational round-robin grant.
  - Inputs: REQ-bit valid vector and `Last_Grant`.
  - Outputs: one-hot grant, encoded index, any-valid.
- Datapath: the team's `BarrelShifter` block instantiated once, `N` passed through.

## Test plan
Configuration for all scenarios: N=32, REQ=4.
- **Single right shift:** req 0 with Data=0x8000_0001, Shift=4, Left=0 → `Resp_Data`=0x0800_0000, `Resp_Id`=0, `Resp_Valid` high 2 cycles after the handshake.
- **Left shift, macro on:** req 2 with Data=0x0000_00FF, Shift=8, Left=1 → `Resp_Data`=0x0000_FF00, `Resp_Id`=2. Macro off: same stimulus → 0x0000_0000.
- **Fairness:** all four `Req_Valid` held high, `Resp_Ready`=1 → grant order 0,1,2,3,0; each `Req_Ready` pulse lasts one cycle.
- **Backpressure:** `Resp_Ready`=0 for 5 cycles in RESP → `Resp_Data`/`Resp_Id` unchanged, `Req_Ready`=0 throughout, completion on the first cycle `Resp_Ready`=1.
- **Extremes:** Data=0xFFFF_FFFF, Shift=31 → 0x0000_0001; Shift=0 → 0xFFFF_FFFF.
- **Reset mid-operation:** assert `Reset` in BUSY after granting req 3 → next cycle `Resp_Valid`=0 and no response ever for req 3; with reqs 0 and 3 valid afterwards, req 0 is granted first.

Source files
------------

// File: rtl/shift_arb_pkg.sv
// shift_arb_pkg: FSM state type and width helpers shared by shift_arbiter and its sub-blocks
package shift_arb_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    function automatic int shw(input int n);
        return $clog2(n);
    endfunction
    function automatic int idw(input int req);
        return $clog2(req);
    endfunction
endpackage

// File: rtl/BarrelShifter.sv
// BarrelShifter: logical right shift of din by shamt, one conditional stage per shamt bit
//   din   : operand
//   shamt : shift amount, $clog2(N) bits
//   dout  : din >> shamt, zero-filled
module BarrelShifter #(
    parameter int N = 32
) (
    input  logic [N-1:0]         din,
    input  logic [$clog2(N)-1:0] shamt,
    output logic [N-1:0]         dout
);
    always_comb begin
        dout = din;
        for (int i = 0; i < $clog2(N); i++) dout = shamt[i] ? dout >> (1 << i) : dout;
    end
endmodule

// File: rtl/shift_rr_grant.sv
// shift_rr_grant: combinational round-robin pick of the first valid requester after last_grant
//   valid      : per-requester request vector
//   last_grant : index granted most recently
//   grant      : one-hot grant
//   idx        : encoded grant index
//   any        : at least one requester valid
module shift_rr_grant
    import shift_arb_pkg::*;
#(
    parameter int REQ = 4
) (
    input  logic [REQ-1:0]       valid,
    input  logic [idw(REQ)-1:0]  last_grant,
    output logic [REQ-1:0]       grant,
    output logic [idw(REQ)-1:0]  idx,
    output logic                 any
);
    localparam int IDW = idw(REQ);
    // Walk from the farthest candidate down so the nearest one after last_grant wins;
    // the IDW-bit sum wraps modulo REQ because REQ is a power of two.
    always_comb begin
        idx = '0;
        for (int i = REQ; i >= 1; i--) if (valid[last_grant + IDW'(i)]) idx = last_grant + IDW'(i);
        any = |valid;
        grant = any ? REQ'(1) << idx : '0;
    end
endmodule

// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin sharing of one barrel shifter among REQ requesters
//   Clk, Reset  : clock, synchronous active-high reset
//   Req_Valid/Req_Ready : per-requester handshake, Req_Ready only in IDLE
//   Req_Data/Req_Shift/Req_Left : per-requester operand, shift amount, direction
//   Resp_Valid/Resp_Ready : registered response handshake
//   Resp_Data/Resp_Id : shifted result and owning requester
//   SHIFT_ARB_LEFT_EN : when defined, Req_Left selects a left shift through bit reversal;
//                       otherwise every operation is a logical right shift
module shift_arbiter
    import shift_arb_pkg::*;
#(
    parameter int N   = 32,
    parameter int REQ = 4
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [REQ-1:0]          Req_Valid,
    output logic [REQ-1:0]          Req_Ready,
    input  logic [REQ*N-1:0]        Req_Data,
    input  logic [REQ*shw(N)-1:0]   Req_Shift,
    input  logic [REQ-1:0]          Req_Left,
    output logic                    Resp_Valid,
    input  logic                    Resp_Ready,
    output logic [N-1:0]            Resp_Data,
    output logic [idw(REQ)-1:0]     Resp_Id
);
    localparam int SHW = shw(N);
    localparam int IDW = idw(REQ);
    state_t state, state_nx;
    logic [IDW-1:0] last_grant, idx;
    logic [REQ-1:0] grant;
    logic any;
    logic [N-1:0] op_data, sh_in, sh_out, result;
    logic [SHW-1:0] op_shift;
    shift_rr_grant #(.REQ(REQ)) u_grant (
        .valid      (Req_Valid),
        .last_grant (last_grant),
        .grant      (grant),
        .idx        (idx),
        .any        (any)
    );
    BarrelShifter #(.N(N)) u_shifter (
        .din   (sh_in),
        .shamt (op_shift),
        .dout  (sh_out)
    );
`ifdef SHIFT_ARB_LEFT_EN
    logic op_left;
    logic [N-1:0] rev_in, rev_out;
    for (genvar j = 0; j < N; j++) begin : g_rev
        assign rev_in[j]  = op_data[N-1-j];
        assign rev_out[j] = sh_out[N-1-j];
    end
    assign sh_in  = op_left ? rev_in : op_data;
    assign result = op_left ? rev_out : sh_out;
`else
    logic unused_left;
    assign unused_left = ^Req_Left;
    assign sh_in  = op_data;
    assign result = sh_out;
`endif
    always_comb begin
        state_nx = state == IDLE ? (any ? BUSY : IDLE) : state == BUSY ? RESP : (Resp_Ready ? IDLE : RESP);
        Req_Ready = (state == IDLE && !Reset) ? grant : '0;
        Resp_Valid = state == RESP;
    end
    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else state <= state_nx;
    end
    always_ff @(posedge Clk) begin
        if (Reset) begin
            last_grant <= IDW'(REQ - 1);
            op_data <= '0;
            op_shift <= '0;
            Resp_Data <= '0;
            Resp_Id <= '0;
`ifdef SHIFT_ARB_LEFT_EN
            op_left <= 1'b0;
`endif
        end else begin
            if (state == IDLE && any) begin
                op_data <= Req_Data[idx*N +: N];
                op_shift <= Req_Shift[idx*SHW +: SHW];
                Resp_Id <= idx;
                last_grant <= idx;
`ifdef SHIFT_ARB_LEFT_EN
                op_left <= Req_Left[idx];
`endif
            end
            if (state == BUSY) Resp_Data <= result;
        end
    end
endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: directed and random checks of shift_arbiter against a behavioural model
module tb_shift_arbiter;
    localparam int N = 32;
    localparam int REQ = 4;
`ifdef SHIFT_ARB_LEFT_EN
    localparam bit LEFT_EN = 1'b1;
`else
    localparam bit LEFT_EN = 1'b0;
`endif
    logic Clk = 1'b0;
    logic Reset = 1'b1;
    logic [REQ-1:0] Req_Valid = '0;
    logic [REQ-1:0] Req_Ready;
    logic [REQ*N-1:0] Req_Data = '0;
    logic [REQ*5-1:0] Req_Shift = '0;
    logic [REQ-1:0] Req_Left = '0;
    logic Resp_Valid;
    logic Resp_Ready = 1'b0;
    logic [N-1:0] Resp_Data;
    logic [1:0] Resp_Id;
    int total = 0;
    int bad = 0;
    int last = 3;
    logic [31:0] d [4];
    logic [4:0] s [4];
    logic l [4];

    always #5 Clk = ~Clk;

    shift_arbiter #(.N(N), .REQ(REQ)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Req_Valid  (Req_Valid),
        .Req_Ready  (Req_Ready),
        .Req_Data   (Req_Data),
        .Req_Shift  (Req_Shift),
        .Req_Left   (Req_Left),
        .Resp_Valid (Resp_Valid),
        .Resp_Ready (Resp_Ready),
        .Resp_Data  (Resp_Data),
        .Resp_Id    (Resp_Id)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] x, input int sh, input logic left);
        return (left && LEFT_EN) ? x << sh : x >> sh;
    endfunction

    function automatic int pick(input logic [3:0] v);
        for (int k = 1; k <= REQ; k++) if (v[(last + k) % REQ]) return (last + k) % REQ;
        return 0;
    endfunction

    task automatic load();
        for (int k = 0; k < REQ; k++) begin
            Req_Data[k*N +: N] = d[k];
            Req_Shift[k*5 +: 5] = s[k];
            Req_Left[k] = l[k];
        end
    endtask

    task automatic set_op(input int k, input logic [31:0] data, input logic [4:0] sh, input logic left);
        d[k] = data;
        s[k] = sh;
        l[k] = left;
    endtask

    // Starts just after a rising edge with the DUT in IDLE; ends the same way.
    task automatic run_op(input logic [3:0] v, input int hold, input bit keep);
        int g;
        logic [31:0] exp;
        logic [1:0] id;
        load();
        Req_Valid = v;
        Resp_Ready = (hold == 0);
        g = pick(v);
        exp = ref_shift(d[g], int'(s[g]), l[g]);
        id = 2'(g);
        @(negedge Clk);
        check("grant", 32'(Req_Ready), 32'(4'b0001 << g));
        check("idle_resp_valid", 32'(Resp_Valid), 32'd0);
        last = g;
        @(posedge Clk); #1;
        if (!keep) Req_Valid = '0;
        @(negedge Clk);
        check("busy_req_ready", 32'(Req_Ready), 32'd0);
        check("busy_resp_valid", 32'(Resp_Valid), 32'd0);
        @(posedge Clk); #1;
        for (int i = 0; i <= hold; i++) begin
            @(negedge Clk);
            check("resp_valid", 32'(Resp_Valid), 32'd1);
            check("resp_data", Resp_Data, exp);
            check("resp_id", 32'(Resp_Id), 32'(id));
            check("resp_req_ready", 32'(Req_Ready), 32'd0);
            @(posedge Clk); #1;
            Resp_Ready = (i + 1 >= hold);
        end
    endtask

    // Grants the requester picked from v, then resets while the operation is in BUSY.
    task automatic grant_then_reset(input logic [3:0] v);
        int g;
        load();
        Req_Valid = v;
        Resp_Ready = 1'b1;
        g = pick(v);
        @(negedge Clk);
        check("rst_grant", 32'(Req_Ready), 32'(4'b0001 << g));
        @(posedge Clk); #1;
        Req_Valid = '0;
        Reset = 1'b1;
        @(posedge Clk); #1;
        Reset = 1'b0;
        last = REQ - 1;
        repeat (3) begin
            @(negedge Clk);
            check("rst_no_resp", 32'(Resp_Valid), 32'd0);
            check("rst_no_ready", 32'(Req_Ready), 32'd0);
            @(posedge Clk); #1;
        end
    endtask

    initial begin
        for (int k = 0; k < REQ; k++) set_op(k, 32'h0, 5'd0, 1'b0);
        Req_Valid = 4'b1111;
        @(posedge Clk); #1;
        @(negedge Clk);
        check("in_reset_ready", 32'(Req_Ready), 32'd0);
        @(posedge Clk); #1;
        Reset = 1'b0;
        Req_Valid = '0;
        @(negedge Clk);
        check("reset_ready", 32'(Req_Ready), 32'd0);
        check("reset_resp_valid", 32'(Resp_Valid), 32'd0);
        check("reset_resp_data", Resp_Data, 32'd0);
        check("reset_resp_id", 32'(Resp_Id), 32'd0);
        @(posedge Clk); #1;

        set_op(0, 32'h8000_0001, 5'd4, 1'b0);
        run_op(4'b0001, 0, 0);

        set_op(2, 32'h0000_00FF, 5'd8, 1'b1);
        run_op(4'b0100, 0, 0);

        set_op(3, 32'hDEAD_BEEF, 5'd12, 1'b0);
        run_op(4'b1000, 5, 0);

        set_op(0, 32'h1234_5678, 5'd1, 1'b0);
        set_op(1, 32'h8765_4321, 5'd3, 1'b1);
        set_op(2, 32'hA5A5_A5A5, 5'd16, 1'b0);
        set_op(3, 32'h0F0F_0F0F, 5'd7, 1'b1);
        repeat (5) run_op(4'b1111, 0, 1);
        Req_Valid = '0;

        set_op(1, 32'hFFFF_FFFF, 5'd31, 1'b0);
        run_op(4'b0010, 0, 0);
        set_op(1, 32'hFFFF_FFFF, 5'd0, 1'b0);
        run_op(4'b0010, 1, 0);
        set_op(2, 32'hFFFF_FFFF, 5'd31, 1'b1);
        run_op(4'b0100, 0, 0);

        set_op(3, 32'hCAFE_F00D, 5'd5, 1'b0);
        grant_then_reset(4'b1000);
        set_op(0, 32'h0000_F000, 5'd12, 1'b0);
        run_op(4'b1001, 0, 0);

        set_op(1, 32'h0001_0000, 5'd16, 1'b0);
        grant_then_reset(4'b0010);
        run_op(4'b0110, 0, 0);

        for (int t = 0; t < 40; t++) begin
            for (int k = 0; k < REQ; k++) set_op(k, 32'($urandom), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
            run_op(4'($urandom_range(1, 15)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end
        Req_Valid = '0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
